// File: rtl/nmr_chip_config_shifter.sv
// nmr_chip_config_shifter
// Serializes four 32-bit configuration words into the NMR chip's serial
// configuration chain (word0 first, MSB first). While shifting, it captures
// the bits that come back on chip_sdo. It then pulses chip_load and returns
// the captured bits as readback words.
//
// Ports:
//   clock              system clock, rising edge
//   reset              synchronous, active-high
//   start              single-cycle pass request (honoured only in IDLE)
//   cfg_word0..3       configuration words, snapshotted on start
//   chip_sdo           serial data returned from the chip chain
//   chip_sclk          serial clock to the chip
//   chip_sdata         serial data to the chip
//   chip_load          latch strobe to the chip, LOAD_CYCLES wide
//   busy               high from SETUP through LOAD
//   done               single-cycle completion pulse
//   rb_word0..3        readback from the last completed pass
module nmr_chip_config_shifter #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned LOAD_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] cfg_word0,
  input  logic [31:0] cfg_word1,
  input  logic [31:0] cfg_word2,
  input  logic [31:0] cfg_word3,
  input  logic        chip_sdo,
  output logic        chip_sclk,
  output logic        chip_sdata,
  output logic        chip_load,
  output logic        busy,
  output logic        done,
  output logic [31:0] rb_word0,
  output logic [31:0] rb_word1,
  output logic [31:0] rb_word2,
  output logic [31:0] rb_word3
);

  localparam int unsigned SHIFT_W = 128;
  localparam int unsigned DIV_W   = 8;
  localparam int unsigned BIT_W   = 8;
  localparam int unsigned LOAD_W  = 4;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [LOAD_W-1:0] LOAD_LAST = LOAD_W'(LOAD_CYCLES - 1);
  localparam logic [BIT_W-1:0]  BIT_TOTAL = BIT_W'(SHIFT_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_LOAD,
    S_DONE
  } state_e;

  state_e               state_q;
  logic [DIV_W-1:0]     div_q;
  logic [BIT_W-1:0]     bit_q;
  logic [LOAD_W-1:0]    load_q;
  logic [SHIFT_W-1:0]   shift_q;
  logic [SHIFT_W-1:0]   cap_q;
  logic [SHIFT_W-1:0]   rb_q;
  logic                 sclk_q;
  logic                 load_pulse_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 div_last_c;
  logic [SHIFT_W-1:0]   shift_d;
  logic [SHIFT_W-1:0]   cap_d;

  // Phase-end detect and the per-bit shift/capture values used on the HIGH->LOW edge
  always_comb begin
    div_last_c = (div_q == DIV_LAST);
    shift_d    = {shift_q[SHIFT_W-2:0], 1'b0};
    cap_d      = {cap_q[SHIFT_W-2:0], chip_sdo};
  end

  // Pass sequencer; all outputs are registered and updated on state transitions
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      bit_q        <= '0;
      load_q       <= '0;
      shift_q      <= '0;
      cap_q        <= '0;
      rb_q         <= '0;
      sclk_q       <= 1'b0;
      load_pulse_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            shift_q <= {cfg_word0, cfg_word1, cfg_word2, cfg_word3};
            bit_q   <= '0;
            div_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (div_last_c) begin
            div_q   <= '0;
            sclk_q  <= 1'b1;
            state_q <= S_HIGH;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        S_HIGH: begin
          // Sample chip_sdo at the end of HIGH; the next data bit appears on the
          // same edge that lowers SCLK, so the chip sees it for all of LOW+HIGH.
          if (div_last_c) begin
            div_q   <= '0;
            cap_q   <= cap_d;
            shift_q <= shift_d;
            bit_q   <= bit_q + BIT_W'(1);
            sclk_q  <= 1'b0;
            state_q <= S_LOW;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        S_LOW: begin
          if (div_last_c) begin
            div_q <= '0;
            if (bit_q == BIT_TOTAL) begin
              load_q       <= '0;
              load_pulse_q <= 1'b1;
              state_q      <= S_LOAD;
            end else begin
              sclk_q  <= 1'b1;
              state_q <= S_HIGH;
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        S_LOAD: begin
          if (load_q == LOAD_LAST) begin
            load_pulse_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            rb_q         <= cap_q;
            state_q      <= S_DONE;
          end else begin
            load_q <= load_q + LOAD_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // After 128 zero-filling shifts the register is empty, so sdata is 0 in LOAD/DONE/IDLE
  assign chip_sclk  = sclk_q;
  assign chip_sdata = shift_q[SHIFT_W-1];
  assign chip_load  = load_pulse_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign rb_word0   = rb_q[127:96];
  assign rb_word1   = rb_q[95:64];
  assign rb_word2   = rb_q[63:32];
  assign rb_word3   = rb_q[31:0];

endmodule

// File: tb/tb_nmr_chip_config_shifter.sv
// Bench for nmr_chip_config_shifter: instance a at default parameters,
// instance b at CLK_DIV=1, LOAD_CYCLES=1. Each instance drives its own chip
// chain model. The model samples on the SCLK rise and shifts on the SCLK fall,
// and it drives chip_sdo from the chain MSB.
module tb_nmr_chip_config_shifter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [127:0] chain;
    logic [127:0] rb;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  // ---------------- instance a (defaults) ----------------
  logic        reset_a, start_a, sdo_a, sclk_a, sdata_a, load_a, busy_a, done_a;
  logic [31:0] cfg0_a, cfg1_a, cfg2_a, cfg3_a, rb0_a, rb1_a, rb2_a, rb3_a;

  nmr_chip_config_shifter #(.CLK_DIV(4), .LOAD_CYCLES(2)) u_dut_a (
    .clock(clock), .reset(reset_a), .start(start_a),
    .cfg_word0(cfg0_a), .cfg_word1(cfg1_a), .cfg_word2(cfg2_a), .cfg_word3(cfg3_a),
    .chip_sdo(sdo_a), .chip_sclk(sclk_a), .chip_sdata(sdata_a), .chip_load(load_a),
    .busy(busy_a), .done(done_a),
    .rb_word0(rb0_a), .rb_word1(rb1_a), .rb_word2(rb2_a), .rb_word3(rb3_a)
  );

  // ---------------- instance b (fast corner) ----------------
  logic        reset_b, start_b, sdo_b, sclk_b, sdata_b, load_b, busy_b, done_b;
  logic [31:0] cfg0_b, cfg1_b, cfg2_b, cfg3_b, rb0_b, rb1_b, rb2_b, rb3_b;

  nmr_chip_config_shifter #(.CLK_DIV(1), .LOAD_CYCLES(1)) u_dut_b (
    .clock(clock), .reset(reset_b), .start(start_b),
    .cfg_word0(cfg0_b), .cfg_word1(cfg1_b), .cfg_word2(cfg2_b), .cfg_word3(cfg3_b),
    .chip_sdo(sdo_b), .chip_sclk(sclk_b), .chip_sdata(sdata_b), .chip_load(load_b),
    .busy(busy_b), .done(done_b),
    .rb_word0(rb0_b), .rb_word1(rb1_b), .rb_word2(rb2_b), .rb_word3(rb3_b)
  );

  // ---------------- chip chain models ----------------
  logic [127:0] chain_a = '0;
  logic [127:0] chain_b = '0;
  logic         in_a = 1'b0;
  logic         in_b = 1'b0;

  always @(posedge sclk_a) in_a <= sdata_a;
  always @(negedge sclk_a) chain_a <= {chain_a[126:0], in_a};
  always @(posedge sclk_b) in_b <= sdata_b;
  always @(negedge sclk_b) chain_b <= {chain_b[126:0], in_b};
  assign sdo_a = chain_a[127];
  assign sdo_b = chain_b[127];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- monitors + scoreboard pop ----------------
  int busy_cyc_a = 0, rise_a = 0, load_cyc_a = 0, load_rise_a = 0, done_cnt_a = 0, load_bad_a = 0;
  int busy_cyc_b = 0, rise_b = 0, tog_b = 0, load_cyc_b = 0, load_rise_b = 0, done_cnt_b = 0;
  logic sclk_prev_a = 1'b0, load_prev_a = 1'b0, sclk_prev_b = 1'b0, load_prev_b = 1'b0;

  always @(negedge clock) begin
    exp_t e;
    if (busy_a) busy_cyc_a++;
    if (sclk_a && !sclk_prev_a) rise_a++;
    if (load_a) load_cyc_a++;
    if (load_a && !load_prev_a) load_rise_a++;
    if (load_a && (sclk_a || sdata_a)) load_bad_a++;
    sclk_prev_a = sclk_a;
    load_prev_a = load_a;
    if (done_a) begin
      done_cnt_a++;
      if (q_a.size() == 0) begin
        check("sb_a_unexpected_done", 128'(1), 128'(0));
      end else begin
        e = q_a.pop_front();
        check("sb_a_chain", chain_a, e.chain);
        check("sb_a_rb", {rb0_a, rb1_a, rb2_a, rb3_a}, e.rb);
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (busy_b) busy_cyc_b++;
    if (sclk_b && !sclk_prev_b) rise_b++;
    if (sclk_b != sclk_prev_b) tog_b++;
    if (load_b) load_cyc_b++;
    if (load_b && !load_prev_b) load_rise_b++;
    sclk_prev_b = sclk_b;
    load_prev_b = load_b;
    if (done_b) begin
      done_cnt_b++;
      if (q_b.size() == 0) begin
        check("sb_b_unexpected_done", 128'(1), 128'(0));
      end else begin
        e = q_b.pop_front();
        check("sb_b_chain", chain_b, e.chain);
        check("sb_b_rb", {rb0_b, rb1_b, rb2_b, rb3_b}, e.rb);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_cfg(input bit which, input logic [127:0] w);
    if (which) {cfg0_b, cfg1_b, cfg2_b, cfg3_b} = w;
    else       {cfg0_a, cfg1_a, cfg2_a, cfg3_a} = w;
  endtask

  // Push the expected chain (the config snapshot) and readback (chain before the pass)
  task automatic kick(input bit which);
    exp_t e;
    if (which) begin
      e.chain = {cfg0_b, cfg1_b, cfg2_b, cfg3_b};
      e.rb    = chain_b;
      q_b.push_back(e);
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
    end else begin
      e.chain = {cfg0_a, cfg1_a, cfg2_a, cfg3_a};
      e.rb    = chain_a;
      q_a.push_back(e);
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
    end
  endtask

  task automatic wait_done(input bit which, input int limit);
    int n = 0;
    while (!(which ? done_b : done_a) && n < limit) begin
      tick();
      n++;
    end
    check(which ? "done_b_timeout" : "done_a_timeout", 128'(which ? done_b : done_a), 128'(1));
  endtask

  localparam logic [127:0] WORDS_A = {32'h80000001, 32'h12345678, 32'h00000000, 32'hFFFFFFFF};
  localparam logic [127:0] WORDS_B = {4{32'hA5A5A5A5}};

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench watchdog");
  end

  initial begin
    int b_busy, b_rise, b_lcyc, b_lrise, b_done, b_bad, b_tog;

    reset_a = 1'b1; reset_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    set_cfg(1'b0, '0);
    set_cfg(1'b1, '0);
    tick(); tick();
    check("rst_outs_a", 128'({sclk_a, sdata_a, load_a, busy_a, done_a}), 128'(0));
    check("rst_rb_a", {rb0_a, rb1_a, rb2_a, rb3_a}, '0);
    check("rst_outs_b", 128'({sclk_b, sdata_b, load_b, busy_b, done_b}), 128'(0));
    reset_a = 1'b0; reset_b = 1'b0;
    tick();

    // Basic shift
    set_cfg(1'b0, WORDS_A);
    b_busy = busy_cyc_a; b_rise = rise_a; b_lcyc = load_cyc_a; b_lrise = load_rise_a;
    b_done = done_cnt_a; b_bad = load_bad_a;
    kick(1'b0);
    check("busy_rise_a", 128'(busy_a), 128'(1));
    check("first_bit_a", 128'(sdata_a), 128'(1));
    wait_done(1'b0, 1100);
    check("busy_cycles_a", 128'(busy_cyc_a - b_busy), 128'(1030));
    check("sclk_rises_a", 128'(rise_a - b_rise), 128'(128));
    check("load_cycles_a", 128'(load_cyc_a - b_lcyc), 128'(2));
    check("load_pulses_a", 128'(load_rise_a - b_lrise), 128'(1));
    check("load_quiet_a", 128'(load_bad_a - b_bad), 128'(0));
    check("rb_after_A", {rb0_a, rb1_a, rb2_a, rb3_a}, '0);
    tick();
    check("done_width_a", 128'(done_a), 128'(0));
    check("done_count_a", 128'(done_cnt_a - b_done), 128'(1));

    // Readback loop
    set_cfg(1'b0, WORDS_B);
    kick(1'b0);
    wait_done(1'b0, 1100);
    check("rb_after_B", {rb0_a, rb1_a, rb2_a, rb3_a}, WORDS_A);
    tick(); tick();

    // Start while busy, including on the DONE cycle
    set_cfg(1'b0, {32'h0F0F1234, 32'hCAFEF00D, 32'h00FF00FF, 32'h13579BDF});
    b_rise = rise_a; b_done = done_cnt_a;
    kick(1'b0);
    for (int c = 1; c < 1100 && !done_a; c++) begin
      if (c == 10 || c == 500) start_a = 1'b1;
      tick();
      start_a = 1'b0;
    end
    check("done_a_timeout_sb", 128'(done_a), 128'(1));
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (20) tick();
    check("no_requeue_busy", 128'(busy_a), 128'(0));
    check("one_pass_rises", 128'(rise_a - b_rise), 128'(128));
    check("one_pass_done", 128'(done_cnt_a - b_done), 128'(1));

    // Config change mid-pass
    set_cfg(1'b0, {32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888});
    kick(1'b0);
    repeat (299) tick();
    cfg1_a = 32'hDEADBEEF;
    wait_done(1'b0, 1100);
    tick(); tick();

    // Reset mid-pass
    set_cfg(1'b0, {32'hFEDCBA98, 32'h76543210, 32'h0000FFFF, 32'hAAAA5555});
    kick(1'b0);
    repeat (598) tick();
    check("busy_before_rst", 128'(busy_a), 128'(1));
    reset_a = 1'b1;
    tick();
    reset_a = 1'b0;
    check("midrst_outs", 128'({sclk_a, sdata_a, load_a, busy_a, done_a}), 128'(0));
    check("midrst_rb", {rb0_a, rb1_a, rb2_a, rb3_a}, '0);
    q_a.delete();
    b_lrise = load_rise_a; b_done = done_cnt_a;
    repeat (600) tick();
    check("midrst_no_load", 128'(load_rise_a - b_lrise), 128'(0));
    check("midrst_no_done", 128'(done_cnt_a - b_done), 128'(0));
    set_cfg(1'b0, {32'h0BADC0DE, 32'h600DF00D, 32'h00000001, 32'h80000000});
    b_rise = rise_a;
    kick(1'b0);
    wait_done(1'b0, 1100);
    check("post_rst_rises", 128'(rise_a - b_rise), 128'(128));
    tick();

    // Parameter corners: back-to-back passes on instance b
    set_cfg(1'b1, WORDS_A);
    b_busy = busy_cyc_b; b_rise = rise_b; b_tog = tog_b; b_lcyc = load_cyc_b;
    b_lrise = load_rise_b; b_done = done_cnt_b;
    kick(1'b1);
    wait_done(1'b1, 300);
    check("busy_cycles_b1", 128'(busy_cyc_b - b_busy), 128'(258));
    check("sclk_toggles_b1", 128'(tog_b - b_tog), 128'(256));
    check("sclk_rises_b1", 128'(rise_b - b_rise), 128'(128));
    check("load_cycles_b1", 128'(load_cyc_b - b_lcyc), 128'(1));
    tick();
    set_cfg(1'b1, {32'h31415926, 32'h27182818, 32'hFFFF0000, 32'h0000FFFF});
    kick(1'b1);
    check("b2b_accept", 128'(busy_b), 128'(1));
    wait_done(1'b1, 300);
    check("busy_cycles_b2", 128'(busy_cyc_b - b_busy), 128'(516));
    check("sclk_rises_b2", 128'(rise_b - b_rise), 128'(256));
    check("load_pulses_b", 128'(load_rise_b - b_lrise), 128'(2));
    check("rb_b2_is_A", {rb0_b, rb1_b, rb2_b, rb3_b}, WORDS_A);
    tick(); tick();
    check("done_count_b", 128'(done_cnt_b - b_done), 128'(2));
    check("sb_a_drained", 128'(q_a.size()), 128'(0));
    check("sb_b_drained", 128'(q_b.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nmr_chip_config_shifter.md
# nmr_chip_config_shifter

Serializes the four 32-bit configuration words held by the NMR chip configuration register block into the NMR chip's serial configuration chain, then pulses the chip's load strobe. It sits directly downstream of the AXI4-Lite configuration register file: register outputs feed `cfg_word0..3`, and a register-write strobe drives `start`. Bits shifted out of the chip's chain are captured in the same pass and returned as readback words for the register file to expose.

## Interface
Parameters:
- `CLK_DIV`, 4, system clocks per SCLK half-period; legal range 1..255.
- `LOAD_CYCLES`, 2, width of `chip_load` pulse in clocks; legal range 1..15.

Ports:
- `clock` in 1: single system clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: single-cycle request to begin a configuration pass.
- `cfg_word0`..`cfg_word3` in 32 each: configuration words from the register file.
- `chip_sdo` in 1: serial data returned from the chip's chain.
- `chip_sclk` out 1: serial clock to the chip.
- `chip_sdata` out 1: serial data to the chip.
- `chip_load` out 1: latch strobe to the chip.
- `busy` out 1: high while a pass is in progress.
- `done` out 1: single-cycle completion pulse.
- `rb_word0`..`rb_word3` out 32 each: readback captured during the last completed pass.

## Operation
- **Reset values:** all outputs are 0 and the FSM is in IDLE.
- **IDLE:**
  - `start`=1 snapshots `{cfg_word0,cfg_word1,cfg_word2,cfg_word3}` into a 128-bit shift register.
  - The bit counter is cleared and the FSM moves to SETUP.
  - Later changes to `cfg_word*` do not affect a pass already in progress.
- **Bit order:** word0 goes first, MSB first. `chip_sdata` always equals `shift[127]` in SETUP, HIGH and LOW.
- **SETUP:** `chip_sclk`=0 for CLK_DIV clocks, then the FSM moves to HIGH.
- **HIGH:**
  - `chip_sclk`=1 for CLK_DIV clocks.
  - On the last clock of HIGH, `chip_sdo` is shifted into the LSB of the 128-bit capture register.
  - The FSM then moves to LOW.
- **LOW:**
  - `chip_sclk`=0 for CLK_DIV clocks.
  - On the first clock of LOW, the shift register shifts left by 1 and the bit counter increments.
  - After the last clock of LOW: if the counter equals 128, the FSM moves to LOAD; otherwise it moves to HIGH.
- **LOAD:** `chip_load`=1, `chip_sclk`=0 and `chip_sdata`=0 for LOAD_CYCLES clocks, then the FSM moves to DONE.
- **DONE (1 clock):**
  - `done`=1 and `busy`=0.
  - `rb_word0`..`rb_word3` take the capture register value `{rb_word0,rb_word1,rb_word2,rb_word3}`. The first sampled bit lands in `rb_word0[31]`.
  - The FSM returns to IDLE.
- **Readback hold:** `rb_word*` change only in DONE and hold between passes.
- **`busy`:** 1 in SETUP, HIGH, LOW and LOAD; 0 in IDLE and DONE.
- **`start` outside IDLE:** ignored, including in DONE. No queuing.
- **Mid-pass reset:** `reset` takes priority over everything. At the next edge all outputs return to 0, `chip_load` is never asserted for the aborted pass, and `rb_word*` are cleared.
- **Counters:** the divider counter is 8 bits, the bit counter 8 bits, and the load counter 4 bits. None wraps within legal parameter ranges.

## Timing
- `start` is sampled at edge E0. `busy` is 1 from E0 through E0+N−1 and `done` is 1 for the cycle after E0+N.
  - N = CLK_DIV + 256·CLK_DIV + LOAD_CYCLES.
  - At defaults, N = 1030.
- The first SCLK rising edge occurs CLK_DIV clocks after `busy` rises, giving data setup of CLK_DIV clocks.
- Data hold after each falling SCLK is 0 clocks: `chip_sdata` changes on the same edge that lowers SCLK.
- `chip_sdata` is stable for the entire HIGH phase.
- SCLK is low for at least CLK_DIV clocks before `chip_load` rises. 128 rising SCLK edges occur per pass.
- Back-to-back passes: `start` in the first IDLE cycle after DONE is accepted, so the minimum spacing between `done` and the next `busy` is 1 clock.

## Test plan
- **Basic shift:**
  - Stimulus: defaults; `cfg_word0..3` = 0x80000001, 0x12345678, 0x00000000, 0xFFFFFFFF; one `start` pulse.
  - Required: a bench 128-bit chip model sampling on SCLK rise holds exactly those words.
  - Required: 128 rising edges, `busy` high for 1030 clocks, one 2-clock `chip_load` pulse, then a 1-cycle `done`.
- **Readback loop:**
  - Stimulus: chip model chain resets to 0 and drives `chip_sdo` from its MSB; run pass A (words above), then pass B (0xA5A5A5A5 ×4).
  - Required: after A, `rb_word*` = 0. After B, `rb_word*` = the pass-A words.
- **Start while busy:**
  - Stimulus: pulse `start` at cycles 10, 500, and on the DONE cycle.
  - Required: exactly one pass occurs, 128 SCLK edges, and `done` is asserted once.
- **Config change mid-pass:**
  - Stimulus: rewrite `cfg_word1` to 0xDEADBEEF at cycle 300.
  - Required: the chip model receives the original snapshot.
- **Reset mid-pass:**
  - Stimulus: assert `reset` for 1 clock at cycle 600.
  - Required: all outputs are 0 at the next edge, no `chip_load` pulse, `rb_word*` = 0, and a following `start` runs a full, correct pass.
- **Parameter corners:**
  - Stimulus: CLK_DIV=1, LOAD_CYCLES=1, two back-to-back passes.
  - Required: `busy` = 258 clocks per pass, SCLK toggles every clock, the second `start` is accepted 1 cycle after `done`, and both chip-model contents are correct.
